rotor_step_ctrl: RTL and testbench

ROTOR_STEP_CTRL -- requirements
Module: rotor_step_ctrl

---
 rtl/rotor_step_ctrl.sv | 150 +++++++++++++++
 tb/tb_rotor_step_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotor_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rotor_step_ctrl
// Description : Three-rotor stepping controller. Accepts one letter at a
//               time, advances the rotor positions with the double-step
//               rule, then presents letter plus positions to the rotor chain
//               until it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module rotor_step_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_load,
    input  logic [4:0]  cfg_pos0,
    input  logic [4:0]  cfg_pos1,
    input  logic [4:0]  cfg_pos2,
    input  logic [4:0]  cfg_notch0,
    input  logic [4:0]  cfg_notch1,
    input  logic        char_valid,
    input  logic [4:0]  char_in,
    output logic        char_ready,
    output logic        out_valid,
    output logic [4:0]  out_char,
    output logic [4:0]  pos0,
    output logic [4:0]  pos1,
    output logic [4:0]  pos2,
    input  logic        out_ready,
    output logic        err,
    output logic [15:0] char_count
);

    localparam logic [4:0]  C_LAST_LETTER  = 5'd25;
    localparam logic [4:0]  C_NOTCH0_RST   = 5'd16;
    localparam logic [4:0]  C_NOTCH1_RST   = 5'd4;
    localparam logic [15:0] C_COUNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  pos0_q, pos0_d;
    logic [4:0]  pos1_q, pos1_d;
    logic [4:0]  pos2_q, pos2_d;
    logic [4:0]  notch0_q, notch0_d;
    logic [4:0]  notch1_q, notch1_d;
    logic [4:0]  out_char_q, out_char_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    // Fold a 5-bit value (0..31) into 0..25; a single subtraction suffices.
    function automatic logic [4:0] mod26(input logic [4:0] v);
        return (v > C_LAST_LETTER) ? (v - 5'd26) : v;
    endfunction

    // Advance one position with wrap from 25 back to 0.
    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v >= C_LAST_LETTER) ? 5'd0 : (v + 5'd1);
    endfunction

    assign char_ready = (state_q == S_IDLE) && !cfg_load;
    assign out_valid  = (state_q == S_HOLD);
    assign out_char   = out_char_q;
    assign pos0       = pos0_q;
    assign pos1       = pos1_q;
    assign pos2       = pos2_q;
    assign err        = err_q;
    assign char_count = count_q;

    // Next-state logic: configuration load overrides all letter handling.
    always_comb begin
        state_d    = state_q;
        pos0_d     = pos0_q;
        pos1_d     = pos1_q;
        pos2_d     = pos2_q;
        notch0_d   = notch0_q;
        notch1_d   = notch1_q;
        out_char_d = out_char_q;
        err_d      = 1'b0;
        count_d    = count_q;

        if (cfg_load) begin
            pos0_d   = mod26(cfg_pos0);
            pos1_d   = mod26(cfg_pos1);
            pos2_d   = mod26(cfg_pos2);
            notch0_d = mod26(cfg_notch0);
            notch1_d = mod26(cfg_notch1);
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (char_valid) begin
                        if (char_in <= C_LAST_LETTER) begin
                            out_char_d = char_in;
                            state_d    = S_STEP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    // Middle rotor steps on its own notch too (double step).
                    pos0_d = inc26(pos0_q);
                    if ((pos0_q == notch0_q) || (pos1_q == notch1_q))
                        pos1_d = inc26(pos1_q);
                    if (pos1_q == notch1_q)
                        pos2_d = inc26(pos2_q);
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        if (count_q != C_COUNT_MAX)
                            count_d = count_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pos0_q     <= 5'd0;
            pos1_q     <= 5'd0;
            pos2_q     <= 5'd0;
            notch0_q   <= C_NOTCH0_RST;
            notch1_q   <= C_NOTCH1_RST;
            out_char_q <= 5'd0;
            err_q      <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pos0_q     <= pos0_d;
            pos1_q     <= pos1_d;
            pos2_q     <= pos2_d;
            notch0_q   <= notch0_d;
            notch1_q   <= notch1_d;
            out_char_q <= out_char_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotor_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotor_step_ctrl
// Description : Scoreboard bench for rotor_step_ctrl. Accepted letters push
//               their expected letter, positions and presentation cycle; a
//               monitor compares every rising out_valid against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotor_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [4:0]  cfg_pos0 = '0, cfg_pos1 = '0, cfg_pos2 = '0;
    logic [4:0]  cfg_notch0 = '0, cfg_notch1 = '0;
    logic        char_valid = 1'b0;
    logic [4:0]  char_in = '0;
    logic        char_ready;
    logic        out_valid;
    logic [4:0]  out_char;
    logic [4:0]  pos0, pos1, pos2;
    logic        out_ready = 1'b0;
    logic        err;
    logic [15:0] char_count;

    typedef struct {
        logic [4:0] c;
        logic [4:0] p0;
        logic [4:0] p1;
        logic [4:0] p2;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    rotor_step_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_pos0   (cfg_pos0),
        .cfg_pos1   (cfg_pos1),
        .cfg_pos2   (cfg_pos2),
        .cfg_notch0 (cfg_notch0),
        .cfg_notch1 (cfg_notch1),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_ready (char_ready),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .pos0       (pos0),
        .pos1       (pos1),
        .pos2       (pos2),
        .out_ready  (out_ready),
        .err        (err),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

    // Edge counter used to time the out_valid rise.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every rising out_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_char", out_char, e.c);
                chk("pos0", pos0, e.p0);
                chk("pos1", pos1, e.p1);
                chk("pos2", pos2, e.p2);
                chk("latency", cyc, e.cyc);
            end
        end
        prev_ov = out_valid;
    end

    // Offer one letter at a negedge; expected data presented two edges later.
    task automatic offer(input logic [4:0] c, input logic [4:0] e0,
                         input logic [4:0] e1, input logic [4:0] e2);
        int n;
        exp_t e;
        n = 0;
        while (!char_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        char_valid = 1'b1;
        char_in    = c;
        e.c = c; e.p0 = e0; e.p1 = e1; e.p2 = e2; e.cyc = cyc + 2;
        sb.push_back(e);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!char_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 0, 1);
    endtask

    task automatic load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [4:0] n0, input logic [4:0] n1);
        cfg_pos0 = a; cfg_pos1 = b; cfg_pos2 = c;
        cfg_notch0 = n0; cfg_notch1 = n1;
        cfg_load = 1'b1;
        #1 chk("ready_during_load", char_ready, 0);
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pos0", pos0, 0);
        chk("rst_pos1", pos1, 0);
        chk("rst_pos2", pos2, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_count", char_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", char_ready, 1);

        // Basic letter
        out_ready = 1'b1;
        offer(5'd7, 5'd1, 5'd0, 5'd0);
        wait_idle();
        chk("count_1", char_count, 1);

        // Rotor0 at its notch carries into rotor1
        load(5'd16, 5'd0, 5'd0, 5'd16, 5'd4);
        offer(5'd2, 5'd17, 5'd1, 5'd0);
        wait_idle();

        // Double step then plain step
        load(5'd0, 5'd4, 5'd0, 5'd16, 5'd4);
        offer(5'd5, 5'd1, 5'd5, 5'd1);
        offer(5'd6, 5'd2, 5'd5, 5'd1);
        wait_idle();

        // All rotors wrap
        load(5'd25, 5'd25, 5'd25, 5'd25, 5'd25);
        offer(5'd0, 5'd0, 5'd0, 5'd0);
        wait_idle();
        chk("count_5", char_count, 5);

        // Illegal letter
        char_valid = 1'b1;
        char_in    = 5'd30;
        @(negedge clk);
        char_valid = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_ready", char_ready, 1);
        chk("err_pos0", pos0, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_no_step_pos0", pos0, 0);
        offer(5'd3, 5'd1, 5'd0, 5'd0);
        wait_idle();
        chk("count_6", char_count, 6);

        // Long hold, then load discards the pending letter
        load(5'd27, 5'd3, 5'd0, 5'd16, 5'd4);
        out_ready = 1'b0;
        offer(5'd9, 5'd2, 5'd3, 5'd0);
        repeat (10) @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_char", out_char, 9);
        chk("hold_pos0", pos0, 2);
        chk("hold_pos1", pos1, 3);
        char_valid = 1'b1;
        char_in    = 5'd11;
        load(5'd30, 5'd1, 5'd2, 5'd16, 5'd4);
        char_valid = 1'b0;
        chk("load_drop_valid", out_valid, 0);
        chk("load_pos0", pos0, 4);
        chk("load_pos1", pos1, 1);
        chk("load_pos2", pos2, 2);
        chk("load_count", char_count, 6);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("load_letter_ignored", out_valid, 0);

        // Reset while holding a letter
        out_ready = 1'b0;
        offer(5'd1, 5'd5, 5'd1, 5'd2);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_pos0", pos0, 0);
        chk("mid_rst_pos1", pos1, 0);
        chk("mid_rst_char", out_char, 0);
        chk("mid_rst_count", char_count, 0);
        chk("mid_rst_ready", char_ready, 1);
        out_ready = 1'b1;
        offer(5'd7, 5'd1, 5'd0, 5'd0);
        wait_idle();
        chk("final_count", char_count, 1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
